// File: rtl/ofdm_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_tx_pkg
// Purpose  : Shared types and default dimensions for the OFDM TX chain.
// Revision : 1.0
// ============================================================================
package ofdm_tx_pkg;

    localparam int OFDM_SYM_LEN = 192;
    localparam int OFDM_GAP_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_PAD  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ofdm_sym_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_sym_cnt
// Purpose  : Two-level word/symbol counter; frm_last flags the final symbol.
// Revision : 1.0
// ============================================================================
module ofdm_sym_cnt
    import ofdm_tx_pkg::*;
#(
    parameter int SYM_LEN = OFDM_SYM_LEN,
    parameter int NSYM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    input  logic [NSYM_W-1:0] nsym,
    output logic              sym_last,
    output logic              frm_last
);

    localparam int                WCNT_W  = $clog2(SYM_LEN);
    localparam logic [WCNT_W-1:0] c_wlast = WCNT_W'(SYM_LEN - 1);

    logic [WCNT_W-1:0] r_wcnt;
    logic [NSYM_W-1:0] r_scnt;

    assign sym_last = (r_wcnt == c_wlast);
    assign frm_last = (r_scnt == (nsym - NSYM_W'(1)));

    // Both counters return to zero on the frame's final word instead of
    // stepping scnt past nsym-1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wcnt <= '0;
            r_scnt <= '0;
        end else if (inc) begin
            if (sym_last && frm_last) begin
                r_wcnt <= '0;
                r_scnt <= '0;
            end else if (sym_last) begin
                r_wcnt <= '0;
                r_scnt <= r_scnt + NSYM_W'(1);
            end else begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofdm_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_tx_frame_ctrl
// Purpose  : Frames upstream words into OFDM symbols, zero-pads aborted frames.
// Revision : 1.0
// ============================================================================
module ofdm_tx_frame_ctrl
    import ofdm_tx_pkg::*;
#(
    parameter int SYM_LEN = OFDM_SYM_LEN,
    parameter int GAP_LEN = OFDM_GAP_LEN,
    parameter int NSYM_W  = 8
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [5:0]        DAT_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    output logic              ACK_O,
    output logic [5:0]        DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I,
    input  logic [NSYM_W-1:0] NSYM_I,
    output logic              BUSY_O,
    output logic              FRM_DONE_O,
    output logic              TRUNC_O
);

    localparam int                GCNT_W  = $clog2(GAP_LEN + 1);
    localparam logic [GCNT_W-1:0] c_glast = GCNT_W'(GAP_LEN - 1);

    state_t            r_state;
    state_t            w_next;
    logic [NSYM_W-1:0] r_nsym;
    logic [GCNT_W-1:0] r_gcnt;
    logic              r_trunc;
    logic              r_frm_done;
    logic              r_trunc_pulse;
    logic              w_start;
    logic              w_stb;
    logic              w_xfer;
    logic              w_clr;
    logic              w_sym_last;
    logic              w_frm_last;
    logic              w_frame_end;
    logic              w_gap_end;

    assign w_start     = CYC_I & STB_I;
    assign w_stb       = ((r_state == ST_PASS) & STB_I & CYC_I) | (r_state == ST_PAD);
    assign w_xfer      = w_stb & ACK_I;
    assign w_clr       = (r_state == ST_IDLE);
    assign w_frame_end = w_xfer & w_sym_last & w_frm_last;
    assign w_gap_end   = (r_state == ST_GAP) && (r_gcnt == c_glast);

    ofdm_sym_cnt #(
        .SYM_LEN (SYM_LEN),
        .NSYM_W  (NSYM_W)
    ) u_sym_cnt (
        .clk      (CLK_I),
        .rst      (RST_I),
        .inc      (w_xfer),
        .clr      (w_clr),
        .nsym     (r_nsym),
        .sym_last (w_sym_last),
        .frm_last (w_frm_last)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        DAT_O  = '0;
        CYC_O  = 1'b0;
        STB_O  = 1'b0;
        WE_O   = 1'b0;
        ACK_O  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_PASS;
            end
            ST_PASS: begin
                DAT_O = DAT_I;
                CYC_O = 1'b1;
                STB_O = w_stb;
                WE_O  = WE_I;
                ACK_O = ACK_I & STB_I & CYC_I;
                // A completing transfer always outranks an abort.
                if (w_frame_end)  w_next = ST_GAP;
                else if (!CYC_I)  w_next = ST_PAD;
            end
            ST_PAD: begin
                CYC_O = 1'b1;
                STB_O = 1'b1;
                WE_O  = 1'b1;
                if (w_frame_end) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_end) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_nsym        <= '0;
            r_gcnt        <= '0;
            r_trunc       <= 1'b0;
            r_frm_done    <= 1'b0;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_frm_done    <= w_frame_end;
            r_trunc_pulse <= w_frame_end & r_trunc;
            if ((r_state == ST_IDLE) && w_start)
                r_nsym <= (NSYM_I == '0) ? NSYM_W'(1) : NSYM_I;
            if (w_frame_end)
                r_trunc <= 1'b0;
            else if ((r_state == ST_PASS) && !CYC_I)
                r_trunc <= 1'b1;
            if ((r_state == ST_GAP) && !w_gap_end)
                r_gcnt <= r_gcnt + GCNT_W'(1);
            else
                r_gcnt <= '0;
        end
    end

    assign BUSY_O     = (r_state != ST_IDLE);
    assign FRM_DONE_O = r_frm_done;
    assign TRUNC_O    = r_trunc_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofdm_tx_frame_ctrl
// Purpose  : Directed vector table plus multi-cycle sequences, SYM_LEN=4, GAP_LEN=3.
// Revision : 1.0
// ============================================================================
module tb_ofdm_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       RST_I, CYC_I, STB_I, WE_I, ACK_I;
    logic [5:0] DAT_I;
    logic [7:0] NSYM_I;
    logic       ACK_O, CYC_O, STB_O, WE_O, BUSY_O, FRM_DONE_O, TRUNC_O;
    logic [5:0] DAT_O;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer, n_done, n_trunc, n_gapcyc, n_gap_ack, guard;
    logic [7:0] stbp, ackp;

    typedef struct {
        logic [4:0]  ctl;   // rst, cyc, stb, we, ack
        logic [5:0]  dat;
        logic [7:0]  nsym;
        logic [12:0] exp;   // ack_o, dat_o[5:0], cyc_o, stb_o, we_o, busy, done, trunc
    } vec_t;
    vec_t tbl[$];

    ofdm_tx_frame_ctrl #(
        .SYM_LEN (4),
        .GAP_LEN (3),
        .NSYM_W  (8)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (RST_I),
        .DAT_I      (DAT_I),
        .CYC_I      (CYC_I),
        .STB_I      (STB_I),
        .WE_I       (WE_I),
        .ACK_O      (ACK_O),
        .DAT_O      (DAT_O),
        .CYC_O      (CYC_O),
        .STB_O      (STB_O),
        .WE_O       (WE_O),
        .ACK_I      (ACK_I),
        .NSYM_I     (NSYM_I),
        .BUSY_O     (BUSY_O),
        .FRM_DONE_O (FRM_DONE_O),
        .TRUNC_O    (TRUNC_O)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic [4:0] ctl, input logic [5:0] dat, input logic [7:0] nsym,
                                input logic e_ack, input logic [5:0] e_dat, input logic [5:0] e_ctl);
        vec_t v;
        v.ctl  = ctl;
        v.dat  = dat;
        v.nsym = nsym;
        v.exp  = {e_ack, e_dat, e_ctl};
        tbl.push_back(v);
    endfunction

    function automatic logic [12:0] outs();
        return {ACK_O, DAT_O, CYC_O, STB_O, WE_O, BUSY_O, FRM_DONE_O, TRUNC_O};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rst, input logic cyc, input logic stb, input logic we,
                         input logic ack, input logic [5:0] dat, input logic [7:0] nsym);
        @(negedge clk);
        RST_I  = rst;
        CYC_I  = cyc;
        STB_I  = stb;
        WE_I   = we;
        ACK_I  = ack;
        DAT_I  = dat;
        NSYM_I = nsym;
        #1;
        if (STB_O && ACK_I && !RST_I) n_xfer++;
        if (FRM_DONE_O) n_done++;
        if (TRUNC_O) n_trunc++;
        if (BUSY_O && !CYC_O) n_gapcyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_xfer = 0; n_done = 0; n_trunc = 0; n_gapcyc = 0; n_gap_ack = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b0;
        DAT_I = 6'h00; NSYM_I = 8'd0;
        clr_counts();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 8'd0);

        // Truncated frame (NSYM=2, 5 words then abort), GAP, then reset two words into the next frame.
        add(5'b10000, 6'h00, 8'd0, 1'b0, 6'h00, 6'b000000);
        add(5'b01111, 6'h01, 8'd2, 1'b0, 6'h00, 6'b000000);
        add(5'b01111, 6'h01, 8'd2, 1'b1, 6'h01, 6'b111100);
        add(5'b01111, 6'h02, 8'd2, 1'b1, 6'h02, 6'b111100);
        add(5'b01111, 6'h03, 8'd2, 1'b1, 6'h03, 6'b111100);
        add(5'b01111, 6'h04, 8'd2, 1'b1, 6'h04, 6'b111100);
        add(5'b01111, 6'h05, 8'd2, 1'b1, 6'h05, 6'b111100);
        add(5'b00011, 6'h2A, 8'd2, 1'b0, 6'h2A, 6'b101100);
        add(5'b00001, 6'h2A, 8'd2, 1'b0, 6'h00, 6'b111100);
        add(5'b00000, 6'h2A, 8'd2, 1'b0, 6'h00, 6'b111100);
        add(5'b00001, 6'h2A, 8'd2, 1'b0, 6'h00, 6'b111100);
        add(5'b00001, 6'h2A, 8'd2, 1'b0, 6'h00, 6'b111100);
        add(5'b01111, 6'h3F, 8'd1, 1'b0, 6'h00, 6'b000111);
        add(5'b01111, 6'h3F, 8'd1, 1'b0, 6'h00, 6'b000100);
        add(5'b01111, 6'h3F, 8'd1, 1'b0, 6'h00, 6'b000100);
        add(5'b01111, 6'h3F, 8'd1, 1'b0, 6'h00, 6'b000000);
        add(5'b01111, 6'h11, 8'd1, 1'b1, 6'h11, 6'b111100);
        add(5'b01111, 6'h12, 8'd1, 1'b1, 6'h12, 6'b111100);
        add(5'b11111, 6'h13, 8'd1, 1'b1, 6'h13, 6'b111100);
        add(5'b01111, 6'h14, 8'd0, 1'b0, 6'h00, 6'b000000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ctl[4], tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0],
                  tbl[i].dat, tbl[i].nsym);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        check("trunc_total_xfers", 32'(n_xfer), 32'd10);
        check("trunc_done_pulses", 32'(n_done), 32'd1);

        // NSYM=0 frame; CYC_I drops right after the final word (no PAD expected).
        clr_counts();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'(6'h21 + k), 8'd0);
            check($sformatf("zc_dat%0d", k), 32'(DAT_O), 32'(6'h21 + k));
            check($sformatf("zc_ack%0d", k), 32'(ACK_O), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 8'd0);
        check("zc_done", 32'(FRM_DONE_O), 32'd1);
        check("zc_trunc", 32'(TRUNC_O), 32'd0);
        check("zc_cyc_gap", 32'(CYC_O), 32'd0);
        check("zc_xfers", 32'(n_xfer), 32'd4);

        // Request held through GAP must not be acknowledged.
        guard = 0;
        do begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h01, 8'd2);
            if (ACK_O) n_gap_ack++;
            guard++;
        end while (BUSY_O && guard < 10);
        check("gap_bound", 32'(guard < 10), 32'd1);
        check("gap_ack", 32'(n_gap_ack), 32'd0);
        check("gap_cycles", 32'(n_gapcyc), 32'd3);
        check("gap_no_pad", 32'(n_trunc), 32'd0);

        // Full frame NSYM=2, words 1..8, ACK_I always high.
        clr_counts();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'(k + 1), 8'd2);
            check($sformatf("full_dat%0d", k), 32'(DAT_O), 32'(k + 1));
        end
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 8'd0);
        check("full_xfers", 32'(n_xfer), 32'd8);
        check("full_done", 32'(n_done), 32'd1);
        check("full_trunc", 32'(n_trunc), 32'd0);
        check("full_gap", 32'(n_gapcyc), 32'd3);
        check("full_idle", 32'(BUSY_O), 32'd0);

        // NSYM=1 with STB_I gaps and ACK_I stalls: 4 transfers at k=0,3,6,7.
        stbp = 8'b1110_1011;
        ackp = 8'b1100_1101;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h30, 8'd1);
        clr_counts();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, stbp[k], 1'b1, ackp[k], 6'(6'h30 + k), 8'd1);
            check($sformatf("stall_ack%0d", k), 32'(ACK_O), 32'(stbp[k] & ackp[k]));
            check($sformatf("stall_stb%0d", k), 32'(STB_O), 32'(stbp[k]));
        end
        check("stall_no_early_done", 32'(n_done), 32'd0);
        check("stall_xfers", 32'(n_xfer), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 8'd0);
        check("stall_done", 32'(FRM_DONE_O), 32'd1);
        check("stall_trunc", 32'(TRUNC_O), 32'd0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 8'd0);
        check("stall_idle", 32'(BUSY_O), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
